// File: rtl/dmem_responder_pkg.sv
//==============================================================================
// Module      : dmem_responder_pkg
// Description : Shared constants for the data-memory responder: defaults,
//               counter width and FSM state encodings.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package dmem_responder_pkg;

    localparam int unsigned c_DEFAULT_DEPTH_WORDS = 32;
    localparam int unsigned c_DEFAULT_LATENCY     = 2;
    localparam int unsigned c_CNT_W               = 4;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    // Word-index width; never zero so a one-word array still has a port.
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
//==============================================================================
// Module      : dmem_array
// Description : Word array with one synchronous write port and one
//               asynchronous read port. Contents are never reset.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = c_DEFAULT_DEPTH_WORDS,
    parameter int unsigned ADDR_W      = addr_width(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [31:0]       i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Indices past a non-power-of-two depth read as zero.
    assign o_rdata = ({{(32-ADDR_W){1'b0}}, i_raddr} < 32'(DEPTH_WORDS)) ? r_mem[i_raddr] : '0;

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
//==============================================================================
// Module      : dmem_responder
// Description : Fixed-latency CPU data-memory responder with fault check,
//               abandon-on-request-drop and combinational pipeline stall.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = c_DEFAULT_DEPTH_WORDS,
    parameter int unsigned LATENCY     = c_DEFAULT_LATENCY
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        stall_o,
    output logic        err_o
);

    localparam int unsigned        c_AW       = addr_width(DEPTH_WORDS);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_count;
    logic               r_we;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rdata;
    logic               r_ack;
    logic               r_err;

    logic               w_in_idle;
    logic               w_acc_we;
    logic [31:0]        w_acc_addr;
    logic [31:0]        w_acc_wdata;
    logic               w_fault;
    logic               w_complete;
    logic               w_arr_we;
    logic [31:0]        w_arr_rdata;

    // With LATENCY = 1 the access happens on the accepting edge, so the live
    // inputs are used; otherwise the values captured at acceptance.
    assign w_in_idle   = (r_state == c_ST_IDLE);
    assign w_acc_we    = w_in_idle ? we_i    : r_we;
    assign w_acc_addr  = w_in_idle ? addr_i  : r_addr;
    assign w_acc_wdata = w_in_idle ? wdata_i : r_wdata;

    assign w_fault    = (w_acc_addr[1:0] != 2'b00) || (w_acc_addr[31:2] >= 30'(DEPTH_WORDS));
    assign w_complete = req_i &&
                        ((w_in_idle && (LATENCY == 1)) ||
                         ((r_state == c_ST_BUSY) && (r_count == c_CNT_W'(1))));
    assign w_arr_we   = w_complete && w_acc_we && !w_fault && !rst_i;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (c_AW)
    ) u_array (
        .clk     (clk_i),
        .i_we    (w_arr_we),
        .i_waddr (w_acc_addr[c_AW+1:2]),
        .i_wdata (w_acc_wdata),
        .i_raddr (w_acc_addr[c_AW+1:2]),
        .o_rdata (w_arr_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_ST_IDLE;
            r_count <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            if (w_complete) begin
                r_state <= c_ST_RESP;
                r_count <= '0;
                r_ack   <= 1'b1;
                r_err   <= w_fault;
                if (w_fault) begin
                    r_rdata <= '0;
                end else if (!w_acc_we) begin
                    r_rdata <= w_arr_rdata;
                end
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (req_i) begin
                            r_we    <= we_i;
                            r_addr  <= addr_i;
                            r_wdata <= wdata_i;
                            r_count <= c_CNT_LOAD;
                            r_state <= c_ST_BUSY;
                        end
                    end
                    c_ST_BUSY: begin
                        if (!req_i) begin
                            r_state <= c_ST_IDLE;
                            r_count <= '0;
                        end else begin
                            r_count <= r_count - c_CNT_W'(1);
                        end
                    end
                    c_ST_RESP: r_state <= c_ST_IDLE;
                    default:   r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

    assign rdata_o = r_rdata;
    assign ack_o   = r_ack;
    assign err_o   = r_err;
    assign stall_o = req_i & ~r_ack;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
//==============================================================================
// Module      : tb_dmem_responder
// Description : Directed scoreboard bench; one responder at LATENCY 2 and one
//               at LATENCY 1 share clock and reset.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dmem_responder;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [1:0]       req, we, ack, stall, err;
    logic [1:0][31:0] addr, wdata, rdata;

    int               checks;
    int               errors;
    int               cyc;
    int               lat [2];
    int               ack_cyc [2];
    int               c_first;
    logic [31:0]      model_mem [2][32];
    logic [31:0]      last_rdata [2];
    exp_t             sb [$];

    dmem_responder #(.DEPTH_WORDS(32), .LATENCY(2)) u_dut0 (
        .clk_i (clk), .rst_i (rst), .req_i (req[0]), .we_i (we[0]),
        .addr_i (addr[0]), .wdata_i (wdata[0]), .rdata_o (rdata[0]),
        .ack_o (ack[0]), .stall_o (stall[0]), .err_o (err[0])
    );

    dmem_responder #(.DEPTH_WORDS(32), .LATENCY(1)) u_dut1 (
        .clk_i (clk), .rst_i (rst), .req_i (req[1]), .we_i (we[1]),
        .addr_i (addr[1]), .wdata_i (wdata[1]), .rdata_o (rdata[1]),
        .ack_o (ack[1]), .stall_o (stall[1]), .err_o (err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // One transaction on responder d: predict, drive, then check timing and data.
    task automatic access(input int d, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input logic hold);
        exp_t        e;
        exp_t        got;
        logic [29:0] word;
        int          n;
        word  = a[31:2];
        e.err = (a[1:0] != 2'b00) || (word >= 30'd32);
        if (e.err) begin
            e.rdata = 32'h0;
        end else if (w) begin
            model_mem[d][word[4:0]] = wd;
            e.rdata = last_rdata[d];
        end else begin
            e.rdata = model_mem[d][word[4:0]];
        end
        last_rdata[d] = e.rdata;
        sb.push_back(e);

        @(posedge clk); #1;
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
        n = 0;
        forever begin
            @(negedge clk);
            if (ack[d]) break;
            check("stall_busy", {31'b0, stall[d]}, 32'd1);
            if (n >= 20) break;
            n++;
            @(posedge clk); #1;
            we[d] = ~w; addr[d] = $urandom; wdata[d] = $urandom;
        end
        got = sb.pop_front();
        ack_cyc[d] = cyc;
        check("ack_seen",    {31'b0, ack[d]},   32'd1);
        check("ack_latency", n,                 lat[d]);
        check("stall_ack",   {31'b0, stall[d]}, 32'd0);
        check("err",         {31'b0, err[d]},   {31'b0, got.err});
        check("rdata",       rdata[d],          got.rdata);
        if (!hold) begin
            @(posedge clk); #1;
            req[d] = 1'b0;
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        lat[0] = 2; lat[1] = 1;
        rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
        last_rdata[0] = 32'h0; last_rdata[1] = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_ack",   {31'b0, ack[d]},   32'd0);
            check("rst_err",   {31'b0, err[d]},   32'd0);
            check("rst_stall", {31'b0, stall[d]}, 32'd0);
            check("rst_rdata", rdata[d],          32'd0);
        end
        @(posedge clk); #1 rst = 1'b0;

        // Fill every word so later loads never see uninitialised contents.
        for (int i = 0; i < 32; i++) access(0, 1'b1, 32'(i * 4), 32'h5A00_0000 + 32'(i * 32'h0101), 1'b0);
        access(1, 1'b1, 32'h0, 32'h1111_0000, 1'b0);
        access(1, 1'b1, 32'h4, 32'h2222_0004, 1'b0);

        // Store/load round trip, misaligned fault, out-of-range store.
        access(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
        access(0, 1'b0, 32'h10, 32'h0,         1'b0);
        access(0, 1'b0, 32'h13, 32'h0,         1'b0);
        access(0, 1'b0, 32'h10, 32'h0,         1'b0);
        access(0, 1'b1, 32'h80, 32'hBAD0_BAD0, 1'b0);
        for (int i = 0; i < 32; i++) access(0, 1'b0, 32'(i * 4), 32'h0, 1'b0);

        // Abandon: request drops while the store is still in flight.
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h4; wdata[0] = 32'h1234;
        @(posedge clk); #1 req[0] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("abandon_ack",   {31'b0, ack[0]}, 32'd0);
            check("abandon_rdata", rdata[0],        last_rdata[0]);
            @(posedge clk); #1;
        end
        access(0, 1'b0, 32'h4, 32'h0, 1'b0);

        // Reset lands on the edge where the store would have been performed.
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h14; wdata[0] = 32'hA5A5_5A5A;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; req[0] = 1'b0;
        @(negedge clk);
        check("busy_rst_ack",   {31'b0, ack[0]},   32'd0);
        check("busy_rst_err",   {31'b0, err[0]},   32'd0);
        check("busy_rst_stall", {31'b0, stall[0]}, 32'd0);
        check("busy_rst_rdata", rdata[0],          32'd0);
        last_rdata[0] = 32'h0; last_rdata[1] = 32'h0;
        access(0, 1'b0, 32'h14, 32'h0, 1'b0);
        access(0, 1'b0, 32'h10, 32'h0, 1'b0);

        // LATENCY 1: request held across back-to-back loads, then store/load.
        access(1, 1'b0, 32'h0, 32'h0, 1'b1);
        c_first = ack_cyc[1];
        access(1, 1'b0, 32'h4, 32'h0, 1'b0);
        check("b2b_gap", ack_cyc[1] - c_first, 32'd2);
        access(1, 1'b1, 32'h8, 32'hCAFE_F00D, 1'b1);
        access(1, 1'b0, 32'h8, 32'h0,         1'b0);
        access(1, 1'b0, 32'h7E, 32'h0,        1'b0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 32, number of 32-bit words in the data array.
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to ack; legal range 1..15.
REQ-003 Port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_i  input  1  reset, synchronous, active-high.
REQ-005 Port req_i  input  1  CPU MEM-stage access request; held high until ack_o.
REQ-006 Port we_i  input  1  1 = store, 0 = load; sampled at acceptance.
REQ-007 Port addr_i  input  32  byte address (EX/MEM ALU result); sampled at acceptance.
REQ-008 Port wdata_i  input  32  store data; sampled at acceptance.
REQ-009 Port rdata_o  output  32  load data; valid in the ack_o cycle, held until the next load completes.
REQ-010 Port ack_o  output  1  one-cycle completion pulse.
REQ-011 Port stall_o  output  1  pipeline freeze request to PC and all pipeline registers.
REQ-012 Port err_o  output  1  access fault, valid only when ack_o = 1.

Function
REQ-013 The FSM SHALL have the states IDLE, BUSY, RESP.
REQ-014 In IDLE with req_i = 1, the block SHALL capture we_i, addr_i, wdata_i, load the counter with LATENCY-1, and move to BUSY (or to RESP when LATENCY = 1).
REQ-015 In BUSY the counter SHALL decrement each cycle; at 0 the access SHALL be performed and the FSM SHALL move to RESP.
REQ-016 In RESP, ack_o SHALL be 1 for exactly one cycle; the next state SHALL be IDLE.
REQ-017 Acceptance-to-ack latency SHALL be exactly LATENCY cycles (request in cycle 0, ack in cycle LATENCY).
REQ-018 stall_o SHALL equal req_i AND NOT ack_o, combinational, so the pipeline advances in the ack cycle.
REQ-019 Stores SHALL write mem[addr[31:2]] <= wdata only at the BUSY->RESP transition; loads SHALL register rdata_o from the same index at that transition.
REQ-020 An access is faulted when addr[1:0] != 0 or addr[31:2] >= DEPTH_WORDS; a faulted access SHALL ack with err_o = 1, perform no write, and drive rdata_o = 0.
REQ-021 If req_i falls while in BUSY, the transaction SHALL be abandoned: return to IDLE, no write, no ack, rdata_o unchanged.
REQ-022 A req_i still high in the cycle after RESP SHALL be accepted as a new transaction; there SHALL be no idle bubble beyond the IDLE state.
REQ-023 Input changes during BUSY/RESP SHALL have no effect except the abandon case (REQ-021).
REQ-024 A load immediately following a store to the same word SHALL return the stored value.

Reset
REQ-025 When rst_i = 1 at a clock edge, the FSM SHALL go to IDLE, the counter SHALL clear, and rdata_o, ack_o and err_o SHALL become 0; this takes priority over all events.
REQ-026 Reset during BUSY SHALL drop the transaction with no write; array contents SHALL NOT be reset.

Structure
REQ-027 State encodings and the LATENCY/DEPTH_WORDS defaults SHALL reside in the shared CPU package.
REQ-028 The word array SHALL be a sub-module dmem_array (one synchronous write port, one read port); the FSM and fault check SHALL stay in dmem_responder.

Verification
REQ-029 Store 0xDEADBEEF to addr 0x10 with LATENCY = 2, then load 0x10 -> each transaction acks in cycle 2 after acceptance with err_o = 0; load returns 0xDEADBEEF; stall_o is high in cycles 0-1 and low in cycle 2.
REQ-030 Load addr 0x13 -> ack with err_o = 1 and rdata_o = 0; a following load of 0x10 still returns the old value.
REQ-031 Store to 0x80 (word 32, DEPTH_WORDS = 32) -> err_o = 1; words 0-31 are unchanged.
REQ-032 Drop req_i one cycle into a store to 0x04 of 0x1234 -> no ack; a later load of 0x04 returns the previous contents.
REQ-033 Assert rst_i in BUSY during a store -> next cycle IDLE with outputs 0 and no write; a subsequent load of a word written before reset returns its pre-reset value.
REQ-034 Hold req_i for back-to-back loads of 0x00 and 0x04 with LATENCY = 1 -> acks in consecutive-transaction cycles 1 and 3 with correct data.
